// File: rtl/memory_sweep_reader.sv
// Arbiter client that periodically copies NUM_WORDS consecutive shared-memory
// words into a local buffer that the display path can read without arbitration.
module memory_sweep_reader #(
  parameter logic [7:0]  BASE_ADDR      = 8'd0,
  parameter int          NUM_WORDS      = 4,
  parameter int          IDX_W          = 2,
  parameter logic [23:0] REFRESH_CYCLES = 24'd270000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grantedAccess,
  output logic             requestingMemory,
  output logic [7:0]       address,
  output logic             readWrite,
  input  logic [31:0]      dataFromMem,
  input  logic [IDX_W-1:0] rdIndex,
  output logic [31:0]      rdData,
  output logic             sweepDone,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_CAPTURE,
    S_WAIT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W:0]   NUM_W     = (IDX_W + 1)'(NUM_WORDS);
  localparam logic [23:0]      WAIT_LAST = REFRESH_CYCLES - 24'd1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [23:0]       wait_cnt_q, wait_cnt_d;
  logic              done_q, done_d;
  logic              capture_en;
  logic [31:0]       words_q [NUM_WORDS];
  logic [31:0]       rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (grantedAccess) state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = grantedAccess ? S_CAPTURE : S_REQ;
      end
      S_CAPTURE: begin
        // Losing the grant here retries the same word; earlier words are kept.
        if (grantedAccess) begin
          capture_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            wait_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = S_WAIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (REFRESH_CYCLES == 24'd0 || wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end else begin
          wait_cnt_d = wait_cnt_q + 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
    end else if (capture_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (idx_q == IDX_W'(i)) words_q[i] <= dataFromMem;
      end
    end
  end

  // Out-of-range indices read as zero rather than aliasing a real word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if ({1'b0, rdIndex} < NUM_W) begin
      rd_data_q <= words_q[rdIndex];
    end else begin
      rd_data_q <= '0;
    end
  end

  // Decoded straight from state so the request drops with an async reset.
  assign busy             = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_CAPTURE);
  assign requestingMemory = busy;
  assign address          = BASE_ADDR + 8'(idx_q);
  assign readWrite        = 1'b0;
  assign rdData           = rd_data_q;
  assign sweepDone        = done_q;

endmodule
